// File: rtl/upower_multicycle_cu_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// upower_multicycle_cu_pkg - shared states, instruction classes, opcodes
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
package upower_multicycle_cu_pkg;

  localparam int OPCODE_W_DEF = 6;
  localparam int XO_W_DEF     = 9;
  localparam int X_W_DEF      = 10;
  localparam int DS_W_DEF     = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_XO    = 3'd0,
    CLS_X     = 3'd1,
    CLS_DALU  = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4,
    CLS_B     = 3'd5,
    CLS_BC    = 3'd6,
    CLS_ILL   = 3'd7
  } cls_t;

  localparam logic [31:0] OP_EXT = 32'd31;
  localparam logic [31:0] OP_LD  = 32'd58;
  localparam logic [31:0] OP_STD = 32'd62;

  function automatic logic is_alu_class(input cls_t c);
    return (c == CLS_XO) || (c == CLS_X) || (c == CLS_DALU);
  endfunction

  function automatic logic is_mem_class(input cls_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/upower_multicycle_cu_if.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// upower_multicycle_cu_if - control-unit to memory/datapath signal bundle
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
interface upower_multicycle_cu_if
  import upower_multicycle_cu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int XO_W     = XO_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int DS_W     = DS_W_DEF
);
  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic [XO_W-1:0]     xoxo;
  logic [X_W-1:0]      xox;
  logic [DS_W-1:0]     xods;
  logic                mem_ready;
  logic                fetch_req;
  logic                ir_write;
  logic                pc_write;
  logic                reg_read;
  logic                alu_en;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic                branch;
  logic                illegal;
  logic                timeout;
  logic [2:0]          state;

  modport master (
    input  start, opcode, xoxo, xox, xods, mem_ready,
    output fetch_req, ir_write, pc_write, reg_read, alu_en, mem_read,
           mem_write, reg_write, branch, illegal, timeout, state
  );

  modport slave (
    output start, opcode, xoxo, xox, xods, mem_ready,
    input  fetch_req, ir_write, pc_write, reg_read, alu_en, mem_read,
           mem_write, reg_write, branch, illegal, timeout, state
  );
endinterface
`default_nettype wire

// File: rtl/upower_multicycle_cu_classifier.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// upower_multicycle_cu_classifier - opcode/extended-opcode -> instruction class
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module upower_multicycle_cu_classifier
  import upower_multicycle_cu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int XO_W     = XO_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int DS_W     = DS_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [XO_W-1:0]     xoxo,
  input  logic [X_W-1:0]      xox,
  input  logic [DS_W-1:0]     xods,
  output cls_t                cls
);

  logic [31:0] op;
  logic [31:0] ds;

  always_comb begin
    op  = 32'(opcode);
    ds  = 32'(xods);
    cls = CLS_ILL;
    if ((op == OP_EXT) && (xoxo != '0)) begin
      cls = CLS_XO;
    end else if ((op == OP_EXT) && (xox != '0)) begin
      cls = CLS_X;
    end else begin
      case (op)
        32'd14, 32'd15, 32'd24, 32'd26, 32'd28: cls = CLS_DALU;
        32'd32, 32'd34, 32'd40, 32'd42:         cls = CLS_LOAD;
        32'd36, 32'd37, 32'd38, 32'd44:         cls = CLS_STORE;
        32'd18:                                 cls = CLS_B;
        32'd19, 32'd23:                         cls = CLS_BC;
        // DS-form sub-opcodes: ld/ldu/lwa valid, std/stdu valid, rest reserved
        OP_LD:  cls = (ds == 32'd3) ? CLS_ILL : CLS_LOAD;
        OP_STD: cls = (ds > 32'd1)  ? CLS_ILL : CLS_STORE;
        default: cls = CLS_ILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/upower_multicycle_cu.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// upower_multicycle_cu - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module upower_multicycle_cu
  import upower_multicycle_cu_pkg::*;
#(
  parameter int OPCODE_W    = OPCODE_W_DEF,
  parameter int XO_W        = XO_W_DEF,
  parameter int X_W         = X_W_DEF,
  parameter int DS_W        = DS_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  upower_multicycle_cu_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_n, done_state;
  cls_t             cls_q, cls_n, dec_cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait, expire;
  logic             fetch_req_q, exec_read_q, alu_en_q, branch_q, pc_branch_q;
  logic             mem_read_q, mem_write_q, reg_write_q, illegal_q, timeout_q;

  upower_multicycle_cu_classifier #(
    .OPCODE_W (OPCODE_W),
    .XO_W     (XO_W),
    .X_W      (X_W),
    .DS_W     (DS_W)
  ) u_classifier (
    .opcode (bus.opcode),
    .xoxo   (bus.xoxo),
    .xox    (bus.xox),
    .xods   (bus.xods),
    .cls    (dec_cls)
  );

  always_comb begin
    mem_wait   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
    // the cycle that would reach the limit traps only if mem_ready is still low
    expire     = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == CNT_LIMIT - 1'b1);
    done_state = bus.start ? ST_FETCH : ST_IDLE;
    state_n    = state_q;
    cls_n      = cls_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_n = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  state_n = ST_DECODE;
        else if (expire)    state_n = ST_HALT;
      end
      ST_DECODE: begin
        cls_n   = dec_cls;
        state_n = (dec_cls == CLS_ILL) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu_class(cls_q))      state_n = ST_WB;
        else if (is_mem_class(cls_q)) state_n = ST_MEM;
        else                          state_n = done_state;
      end
      ST_MEM: begin
        if (bus.mem_ready)  state_n = (cls_q == CLS_LOAD) ? ST_WB : done_state;
        else if (expire)    state_n = ST_HALT;
      end
      ST_WB:   state_n = done_state;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
  end

  // Moore strobes are registered from the next state/class so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_ILL;
      wait_cnt    <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      fetch_req_q <= 1'b0;
      exec_read_q <= 1'b0;
      alu_en_q    <= 1'b0;
      branch_q    <= 1'b0;
      pc_branch_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cls_q   <= cls_n;
      if (state_n != state_q)
        wait_cnt <= '0;
      else if (mem_wait && (wait_cnt != CNT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
      if ((state_q == ST_DECODE) && (dec_cls == CLS_ILL)) illegal_q <= 1'b1;
      if (expire) timeout_q <= 1'b1;
      fetch_req_q <= (state_n == ST_FETCH);
      exec_read_q <= (state_n == ST_EXEC) && (cls_n != CLS_B);
      alu_en_q    <= (state_n == ST_EXEC) && (cls_n != CLS_B);
      branch_q    <= (state_n == ST_EXEC) && ((cls_n == CLS_B) || (cls_n == CLS_BC));
      pc_branch_q <= (state_n == ST_EXEC) && (cls_n == CLS_B);
      mem_read_q  <= (state_n == ST_MEM) && (cls_n == CLS_LOAD);
      mem_write_q <= (state_n == ST_MEM) && (cls_n == CLS_STORE);
      reg_write_q <= (state_n == ST_WB);
    end
  end

  // DECODE's register read depends on the class being decoded this very cycle
  assign bus.reg_read  = exec_read_q | ((state_q == ST_DECODE) && (dec_cls != CLS_B));
  assign bus.fetch_req = fetch_req_q;
  assign bus.ir_write  = fetch_req_q & bus.mem_ready;
  assign bus.pc_write  = pc_branch_q | (fetch_req_q & bus.mem_ready);
  assign bus.alu_en    = alu_en_q;
  assign bus.branch    = branch_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.reg_write = reg_write_q;
  assign bus.illegal   = illegal_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_upower_multicycle_cu.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// tb_upower_multicycle_cu - directed bench with per-cycle instruction model
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module tb_upower_multicycle_cu;

  localparam int TO = 4;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_HALT = 6;
  localparam int K_XO = 0, K_X = 1, K_DALU = 2, K_LOAD = 3, K_STORE = 4, K_B = 5, K_BC = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  upower_multicycle_cu_if bus ();

  upower_multicycle_cu #(
    .OPCODE_W (6), .XO_W (9), .X_W (10), .DS_W (2), .MEM_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int b2i(input bit b);
    return b ? 1 : 0;
  endfunction

  function automatic int classify(input int op, input int xo, input int x, input int ds);
    if (op == 31 && xo != 0) return K_XO;
    if (op == 31 && x != 0) return K_X;
    if (op inside {14, 15, 24, 26, 28}) return K_DALU;
    if (op == 58 && ds == 3) return K_ILL;
    if (op == 62 && ds > 1) return K_ILL;
    if (op inside {32, 34, 40, 42, 58}) return K_LOAD;
    if (op inside {36, 37, 38, 44, 62}) return K_STORE;
    if (op == 18) return K_B;
    if (op inside {19, 23}) return K_BC;
    return K_ILL;
  endfunction

  function automatic int cur_kind();
    return classify(int'(bus.opcode), int'(bus.xoxo), int'(bus.xox), int'(bus.xods));
  endfunction

  // Model: current phase plus the list of phases still owed by this instruction
  int m_ph = P_IDLE;
  int m_kind = K_ILL;
  int m_wait = 0;
  bit m_ill = 1'b0;
  bit m_to = 1'b0;
  int m_rest[$];

  task automatic start_instr();
    m_ph = P_FETCH;
    m_wait = 0;
    m_rest = {P_DECODE};
  endtask

  task automatic advance();
    if (m_rest.size() == 0) begin
      if (bus.start) start_instr();
      else m_ph = P_IDLE;
    end else begin
      m_ph = m_rest.pop_front();
      m_wait = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_ph = P_IDLE; m_kind = K_ILL; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
      m_rest.delete();
    end else begin
      case (m_ph)
        P_IDLE: if (bus.start) start_instr();
        P_HALT: ;
        P_DECODE: begin
          m_kind = cur_kind();
          if (m_kind == K_ILL) begin
            m_ph = P_HALT; m_ill = 1'b1;
          end else begin
            m_rest = {P_EXEC};
            if (m_kind == K_LOAD || m_kind == K_STORE) m_rest.push_back(P_MEM);
            if (m_kind inside {K_XO, K_X, K_DALU, K_LOAD}) m_rest.push_back(P_WB);
            advance();
          end
        end
        P_FETCH, P_MEM: begin
          if (bus.mem_ready) advance();
          else begin
            m_wait++;
            if (TO != 0 && m_wait >= TO) begin
              m_ph = P_HALT; m_to = 1'b1;
            end
          end
        end
        default: advance();
      endcase
    end
  endtask

  task automatic compare();
    int ph, k;
    bit mr, f;
    ph = m_ph;
    k  = (ph == P_DECODE) ? cur_kind() : m_kind;
    mr = bus.mem_ready;
    f  = (ph == P_FETCH);
    check("state", int'(bus.state), ph);
    check("fetch_req", b2i(bus.fetch_req), b2i(f));
    check("ir_write", b2i(bus.ir_write), b2i(f && mr));
    check("pc_write", b2i(bus.pc_write), b2i((f && mr) || (ph == P_EXEC && k == K_B)));
    check("reg_read", b2i(bus.reg_read), b2i((ph == P_DECODE || ph == P_EXEC) && k != K_B));
    check("alu_en", b2i(bus.alu_en), b2i(ph == P_EXEC && k != K_B));
    check("branch", b2i(bus.branch), b2i(ph == P_EXEC && (k == K_B || k == K_BC)));
    check("mem_read", b2i(bus.mem_read), b2i(ph == P_MEM && k == K_LOAD));
    check("mem_write", b2i(bus.mem_write), b2i(ph == P_MEM && k == K_STORE));
    check("reg_write", b2i(bus.reg_write), b2i(ph == P_WB));
    check("illegal", b2i(bus.illegal), b2i(m_ill));
    check("timeout", b2i(bus.timeout), b2i(m_to));
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) compare();
  end

  function automatic int outs();
    return int'({bus.fetch_req, bus.ir_write, bus.pc_write, bus.reg_read, bus.alu_en,
                 bus.mem_read, bus.mem_write, bus.reg_write, bus.branch, bus.illegal,
                 bus.timeout, bus.state});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic set_instr(input int op, input int xo, input int x, input int ds);
    bus.opcode = 6'(op);
    bus.xoxo   = 9'(xo);
    bus.xox    = 10'(x);
    bus.xods   = 2'(ds);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.state != 3'd0 && n < budget) begin
      tick();
      n++;
    end
    check("return_to_idle", int'(bus.state), 0);
  endtask

  int lat_op[8]  = '{24, 31, 58, 40, 62, 44, 23, 18};
  int lat_x[8]   = '{0, 28, 0, 0, 0, 0, 0, 0};
  int lat_ds[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
  int lat_exp[8] = '{4, 4, 5, 5, 4, 4, 3, 3};
  int ill_op[3]  = '{58, 62, 0};
  int ill_ds[3]  = '{3, 2, 0};

  initial begin : stim
    logic [4:0] st_seq [5];
    logic [4:0] rw_mask;
    logic [9:0] mrd_mask, lrw_mask;
    logic [3:0] br_mask, pcw_mask, rr_mask, rwb_mask;
    int n;

    bus.start = 1'b0; bus.mem_ready = 1'b1;
    set_instr(0, 0, 0, 0);
    do_reset();
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_state", int'(bus.state), 0);
    check("reset_outputs", outs(), 0);
    tick();

    // add: 1,2,3,5 then straight back to FETCH
    set_instr(31, 266, 0, 0);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      st_seq[i] = {2'b00, bus.state};
      rw_mask[i] = bus.reg_write;
      tick();
    end
    bus.start = 1'b0;
    check("add_states", int'({st_seq[0][2:0], st_seq[1][2:0], st_seq[2][2:0], st_seq[3][2:0], st_seq[4][2:0]}),
          int'({3'd1, 3'd2, 3'd3, 3'd5, 3'd1}));
    check("add_reg_write_cycle", int'(rw_mask), int'(5'b01000));
    wait_idle(20);

    // lwz with three mem_ready-low cycles in MEM
    set_instr(32, 0, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.mem_ready = 1'b0;
      if (i == 6) bus.mem_ready = 1'b1;
      @(negedge clk);
      mrd_mask[i] = bus.mem_read;
      lrw_mask[i] = bus.reg_write;
      tick();
    end
    check("lwz_mem_read_cycles", $countones(mrd_mask), 4);
    check("lwz_mem_read_window", int'(mrd_mask), int'(10'b0001111000));
    check("lwz_reg_write_cycle", int'(lrw_mask), int'(10'b0010000000));
    wait_idle(20);

    // b then bc: EXEC is cycle 2
    for (int t = 0; t < 2; t++) begin
      set_instr(t == 0 ? 18 : 19, 0, 0, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        br_mask[i] = bus.branch;
        pcw_mask[i] = bus.pc_write;
        rr_mask[i] = bus.reg_read;
        rwb_mask[i] = bus.reg_write;
        tick();
      end
      check(t == 0 ? "b_branch" : "bc_branch", int'(br_mask), int'(4'b0100));
      check(t == 0 ? "b_pc_write" : "bc_pc_write", int'(pcw_mask), t == 0 ? 5 : 1);
      check(t == 0 ? "b_reg_read" : "bc_reg_read", int'(rr_mask), t == 0 ? 0 : 6);
      check(t == 0 ? "b_reg_write" : "bc_reg_write", int'(rwb_mask), 0);
      wait_idle(20);
    end

    // minimum latency per class, FETCH entry to done
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_instr(lat_op[i], 0, lat_x[i], lat_ds[i]);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.state != 3'd0 && n < 20) begin
        n++;
        tick();
      end
      check($sformatf("latency_op%0d", lat_op[i]), n, lat_exp[i]);
    end

    // illegal encodings trap and survive a long start=1
    for (int i = 0; i < 3; i++) begin
      do_reset();
      set_instr(ill_op[i], 0, 0, ill_ds[i]);
      bus.start = 1'b1;
      repeat (23) tick();
      check($sformatf("ill_op%0d_flag", ill_op[i]), b2i(bus.illegal), 1);
      check($sformatf("ill_op%0d_state", ill_op[i]), int'(bus.state), 6);
      check($sformatf("ill_op%0d_timeout", ill_op[i]), b2i(bus.timeout), 0);
      do_reset();
      check($sformatf("ill_op%0d_cleared", ill_op[i]), b2i(bus.illegal), 0);
    end

    // fetch timeout after TO wait cycles
    do_reset();
    set_instr(14, 0, 0, 0);
    bus.mem_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    repeat (3) tick();
    check("to_last_wait_state", int'(bus.state), 1);
    tick();
    check("to_halt_state", int'(bus.state), 6);
    check("to_flag", b2i(bus.timeout), 1);
    check("to_req_dropped", b2i(bus.fetch_req), 0);
    repeat (3) tick();
    check("to_sticky", int'(bus.state), 6);
    do_reset();
    check("to_cleared", b2i(bus.timeout), 0);

    // mem_ready on the limit cycle wins
    bus.mem_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    repeat (3) tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("to_edge_decode", int'(bus.state), 2);
    check("to_edge_no_trap", b2i(bus.timeout), 0);
    wait_idle(20);

    // load stalls in MEM until timeout
    set_instr(32, 0, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.mem_ready = 1'b0;
    repeat (4) tick();
    check("mem_to_state", int'(bus.state), 6);
    check("mem_to_flag", b2i(bus.timeout), 1);
    check("mem_to_read_dropped", b2i(bus.mem_read), 0);

    // reset in the middle of a store's MEM wait
    do_reset();
    set_instr(36, 0, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("st_mem_write", b2i(bus.mem_write), 1);
    #2 rst = 1'b1;
    #1;
    check("st_rst_mem_write", b2i(bus.mem_write), 0);
    check("st_rst_outputs", outs(), 0);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
